extremum_finder_mc: RTL and testbench

EXTREMUM_FINDER_MC -- requirements
Module: extremum_finder_mc

---
 rtl/extremum_finder_mc.sv | 155 +++++++++++++++
 tb/tb_extremum_finder_mc.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/extremum_finder_mc.sv
// extremum_finder_mc
// Tracks the per-channel signed minimum and maximum over a window of 2^EF_log_count
// accepted AXI-Stream beats. At the end of each window it derives lower and upper thresholds
// by compressing the extremes towards their midpoint by 2^EF_shift.
// Ports:
//   aclk, areset        clock, asynchronous active-high reset
//   EF_enable           run windows while high; dropping it mid-window discards the window
//   EF_log_count        window length exponent, latched at window start
//   EF_shift            compression shift, latched at window start
//   EF_lower_threshold  packed per-channel lower thresholds (signed)
//   EF_upper_threshold  packed per-channel upper thresholds (signed)
//   EF_update           one-cycle pulse after new thresholds are registered
//   S_AXIS_*            sample stream; CHANNEL_COUNT signed lanes packed in tdata
module extremum_finder_mc #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CHANNEL_COUNT    = 2
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        EF_enable,
    input  logic [4:0]                  EF_log_count,
    input  logic [2:0]                  EF_shift,
    output logic [AXIS_TDATA_WIDTH-1:0] EF_lower_threshold,
    output logic [AXIS_TDATA_WIDTH-1:0] EF_upper_threshold,
    output logic                        EF_update,
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                        S_AXIS_tready
);

    localparam int SW = AXIS_TDATA_WIDTH / CHANNEL_COUNT;
    localparam logic signed [SW-1:0] POS_MAX = {1'b0, {(SW-1){1'b1}}};
    localparam logic signed [SW-1:0] NEG_MAX = {1'b1, {(SW-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StMeasure, StUpdate} state_e;

    state_e                        state_q, state_d;
    logic [4:0]                    log_count_q;
    logic [2:0]                    shift_q;
    logic [31:0]                   count_q;
    logic [31:0]                   last_count;
    logic                          update_q;
    logic                          beat;
    logic [AXIS_TDATA_WIDTH-1:0]   lower_q, upper_q, lower_calc, upper_calc;
    logic signed [SW-1:0]          tmp_min_q [CHANNEL_COUNT];
    logic signed [SW-1:0]          tmp_max_q [CHANNEL_COUNT];
    logic signed [SW-1:0]          sample    [CHANNEL_COUNT];
    logic signed [SW:0]            ext_min   [CHANNEL_COUNT];
    logic signed [SW:0]            ext_max   [CHANNEL_COUNT];
    logic signed [SW:0]            center    [CHANNEL_COUNT];

    // Pull one extreme towards the midpoint; one extra bit keeps the difference exact.
    function automatic logic [SW-1:0] compress(input logic signed [SW:0] bound_v,
                                               input logic signed [SW:0] mid,
                                               input logic [2:0]         sh);
        logic signed [SW:0] r;
        r = ((bound_v - mid) >>> sh) + mid;
        return r[SW-1:0];
    endfunction

    assign S_AXIS_tready      = (state_q != StUpdate);
    assign beat               = S_AXIS_tvalid && S_AXIS_tready;
    assign EF_lower_threshold = lower_q;
    assign EF_upper_threshold = upper_q;
    assign EF_update          = update_q;

    // Index of the final beat of the window: 2^log_count - 1, exact for log_count = 31.
    assign last_count = 32'hFFFF_FFFF >> (6'd32 - {1'b0, log_count_q});

    always_comb begin
        lower_calc = '0;
        upper_calc = '0;
        for (int k = 0; k < CHANNEL_COUNT; k++) begin
            sample[k]  = S_AXIS_tdata[k*SW +: SW];
            ext_min[k] = {tmp_min_q[k][SW-1], tmp_min_q[k]};
            ext_max[k] = {tmp_max_q[k][SW-1], tmp_max_q[k]};
            center[k]  = (ext_max[k] + ext_min[k]) >>> 1;
            lower_calc[k*SW +: SW] = compress(ext_min[k], center[k], shift_q);
            upper_calc[k*SW +: SW] = compress(ext_max[k], center[k], shift_q);
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (EF_enable) state_d = StMeasure;
            end
            StMeasure: begin
                // Dropping enable wins over a simultaneous final beat.
                if (!EF_enable) begin
                    state_d = StIdle;
                end else if (beat && (count_q == last_count)) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            log_count_q <= '0;
            shift_q     <= '0;
            count_q     <= '0;
            update_q    <= 1'b0;
            for (int k = 0; k < CHANNEL_COUNT; k++) begin
                tmp_min_q[k]          <= POS_MAX;
                tmp_max_q[k]          <= NEG_MAX;
                lower_q[k*SW +: SW]   <= POS_MAX;
                upper_q[k*SW +: SW]   <= NEG_MAX;
            end
        end else begin
            update_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (EF_enable) begin
                        log_count_q <= EF_log_count;
                        shift_q     <= EF_shift;
                        count_q     <= '0;
                        for (int k = 0; k < CHANNEL_COUNT; k++) begin
                            tmp_min_q[k] <= POS_MAX;
                            tmp_max_q[k] <= NEG_MAX;
                        end
                    end
                end
                StMeasure: begin
                    if (EF_enable && beat) begin
                        count_q <= count_q + 32'd1;
                        for (int k = 0; k < CHANNEL_COUNT; k++) begin
                            if (sample[k] < tmp_min_q[k]) tmp_min_q[k] <= sample[k];
                            if (sample[k] > tmp_max_q[k]) tmp_max_q[k] <= sample[k];
                        end
                    end
                end
                StUpdate: begin
                    lower_q  <= lower_calc;
                    upper_q  <= upper_calc;
                    update_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_extremum_finder_mc.sv
// Self-checking bench for extremum_finder_mc (32-bit tdata, two 16-bit channels).
module tb_extremum_finder_mc;

    logic        aclk = 1'b0;
    logic        areset;
    logic        EF_enable;
    logic [4:0]  EF_log_count;
    logic [2:0]  EF_shift;
    logic [31:0] EF_lower_threshold;
    logic [31:0] EF_upper_threshold;
    logic        EF_update;
    logic        S_AXIS_tvalid;
    logic [31:0] S_AXIS_tdata;
    logic        S_AXIS_tready;

    int          passed = 0;
    int          total  = 0;
    int          cycle  = 0;
    int          pulse_cycle = 0;
    int          q0[$];
    int          q1[$];
    logic [31:0] last_lo, last_hi;

    extremum_finder_mc dut (
        .aclk               (aclk),
        .areset             (areset),
        .EF_enable          (EF_enable),
        .EF_log_count       (EF_log_count),
        .EF_shift           (EF_shift),
        .EF_lower_threshold (EF_lower_threshold),
        .EF_upper_threshold (EF_upper_threshold),
        .EF_update          (EF_update),
        .S_AXIS_tvalid      (S_AXIS_tvalid),
        .S_AXIS_tdata       (S_AXIS_tdata),
        .S_AXIS_tready      (S_AXIS_tready)
    );

    always #5 aclk = ~aclk;

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge aclk);
        #1;
        cycle++;
    endtask

    // Thresholds from the window contents: midpoint of the extremes, then each
    // extreme's distance from it divided by 2^sh (rounded towards -inf).
    task automatic model(input int n, input int sh, output logic [31:0] elo,
                         output logic [31:0] ehi);
        int mn, mx, c, v, lo, hi;
        elo = '0;
        ehi = '0;
        for (int ch = 0; ch < 2; ch++) begin
            mn = 32767;
            mx = -32768;
            for (int i = 0; i < n; i++) begin
                v = (ch == 0) ? q0[i] : q1[i];
                if (v < mn) mn = v;
                if (v > mx) mx = v;
            end
            c  = (mx + mn) >>> 1;
            lo = ((mn - c) >>> sh) + c;
            hi = ((mx - c) >>> sh) + c;
            elo[ch*16 +: 16] = 16'(lo);
            ehi[ch*16 +: 16] = 16'(hi);
        end
    endtask

    // Runs one full window from IDLE using samples in q0/q1 and checks its result.
    task automatic run_window(input int lg, input int sh, input bit rand_valid,
                              input bit scramble, input string name);
        int          n = 1 << lg;
        int          idx = 0;
        int          budget = 0;
        bit          early = 1'b0;
        bit          tr_bad = 1'b0;
        bit          v;
        logic [31:0] elo, ehi;
        EF_enable     = 1'b1;
        EF_log_count  = 5'(lg);
        EF_shift      = 3'(sh);
        S_AXIS_tvalid = 1'b0;
        step();
        if (scramble) begin
            EF_log_count = 5'($urandom);
            EF_shift     = 3'($urandom);
        end
        while (idx < n && budget < 400) begin
            v = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
            S_AXIS_tvalid = v;
            S_AXIS_tdata  = {16'(q1[idx]), 16'(q0[idx])};
            if (S_AXIS_tready !== 1'b1) tr_bad = 1'b1;
            step();
            budget++;
            if (v) idx++;
            if (EF_update !== 1'b0) early = 1'b1;
        end
        S_AXIS_tvalid = 1'b0;
        total++;
        if (idx < n) begin
            $display("FAIL %s timeout: accepted %0d beats, required %0d", name, idx, n);
            return;
        end else passed++;
        total++;
        if (tr_bad || early) $display("FAIL %s window: tready_low=%0b early_update=%0b, required 0/0",
                                      name, tr_bad, early);
        else passed++;
        total++;
        if (S_AXIS_tready !== 1'b0) $display("FAIL %s update_tready: got %b, required 0",
                                             name, S_AXIS_tready);
        else passed++;
        step();
        model(n, sh, elo, ehi);
        total++;
        if (EF_update !== 1'b1) $display("FAIL %s pulse: got %b, required 1", name, EF_update);
        else passed++;
        total++;
        if (EF_lower_threshold !== elo || EF_upper_threshold !== ehi)
            $display("FAIL %s thresholds: got lo=%h hi=%h, required lo=%h hi=%h",
                     name, EF_lower_threshold, EF_upper_threshold, elo, ehi);
        else passed++;
        last_lo     = elo;
        last_hi     = ehi;
        pulse_cycle = cycle;
    endtask

    task automatic test_reset();
        total++;
        if (EF_lower_threshold !== 32'h7FFF_7FFF || EF_upper_threshold !== 32'h8000_8000 ||
            EF_update !== 1'b0 || S_AXIS_tready !== 1'b1)
            $display("FAIL reset: lo=%h hi=%h upd=%b rdy=%b, required 7fff7fff 80008000 0 1",
                     EF_lower_threshold, EF_upper_threshold, EF_update, S_AXIS_tready);
        else passed++;
    endtask

    task automatic test_directed();
        q0 = '{10, -20, 30, 5};
        q1 = '{1, 2, 3, 4};
        run_window(2, 0, 1'b0, 1'b0, "last_beat");
        total++;
        if (EF_lower_threshold[15:0] !== 16'hFFEC || EF_upper_threshold[15:0] !== 16'd30)
            $display("FAIL last_beat_ch0: lo=%h hi=%h, required ffec 001e",
                     EF_lower_threshold[15:0], EF_upper_threshold[15:0]);
        else passed++;
        EF_enable = 1'b0;
        step();
        q0 = '{-10, 30};
        q1 = '{-100, 100};
        run_window(1, 1, 1'b0, 1'b0, "shift1");
        q0 = '{-32768, 32767};
        q1 = '{0, 0};
        run_window(1, 0, 1'b0, 1'b0, "full_range");
        total++;
        if (EF_lower_threshold[15:0] !== 16'h8000 || EF_upper_threshold[15:0] !== 16'h7FFF)
            $display("FAIL full_range_ch0: lo=%h hi=%h, required 8000 7fff",
                     EF_lower_threshold[15:0], EF_upper_threshold[15:0]);
        else passed++;
    endtask

    task automatic test_random_valid();
        logic signed [15:0] r;
        for (int w = 0; w < 4; w++) begin
            q0.delete();
            q1.delete();
            for (int i = 0; i < 8; i++) begin
                r = 16'($urandom);
                q0.push_back(int'(r));
                r = 16'($urandom);
                q1.push_back(int'(r));
            end
            run_window(3, int'($urandom_range(0, 7)), 1'b1, 1'b1, "random_valid");
        end
    endtask

    task automatic test_back_to_back();
        int prev;
        for (int w = 0; w < 6; w++) begin
            prev = pulse_cycle;
            q0 = '{int'($urandom_range(0, 65535)) - 32768};
            q1 = '{int'($urandom_range(0, 65535)) - 32768};
            run_window(0, 0, 1'b0, 1'b0, "back_to_back");
            total++;
            if (EF_lower_threshold !== {16'(q1[0]), 16'(q0[0])})
                $display("FAIL b2b_sample: got %h, required %h", EF_lower_threshold,
                         {16'(q1[0]), 16'(q0[0])});
            else passed++;
            if (w > 0) begin
                total++;
                if (pulse_cycle - prev !== 3)
                    $display("FAIL b2b_period: got %0d cycles, required 3", pulse_cycle - prev);
                else passed++;
            end
        end
    endtask

    task automatic test_abort_reset();
        bit seen = 1'b0;
        EF_enable     = 1'b1;
        EF_log_count  = 5'd2;
        EF_shift      = 3'd0;
        S_AXIS_tvalid = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            S_AXIS_tvalid = 1'b1;
            S_AXIS_tdata  = $urandom;
            step();
        end
        EF_enable     = 1'b0;
        S_AXIS_tvalid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (EF_update !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen || EF_lower_threshold !== last_lo || EF_upper_threshold !== last_hi)
            $display("FAIL abort: upd_seen=%0b lo=%h hi=%h, required 0 %h %h",
                     seen, EF_lower_threshold, EF_upper_threshold, last_lo, last_hi);
        else passed++;
        // Asynchronous reset between clock edges, part-way through a window.
        EF_enable = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin
            S_AXIS_tvalid = 1'b1;
            S_AXIS_tdata  = $urandom;
            step();
        end
        #2 areset = 1'b1;
        #1;
        total++;
        if (EF_lower_threshold !== 32'h7FFF_7FFF || EF_upper_threshold !== 32'h8000_8000 ||
            EF_update !== 1'b0)
            $display("FAIL async_reset: lo=%h hi=%h upd=%b, required 7fff7fff 80008000 0",
                     EF_lower_threshold, EF_upper_threshold, EF_update);
        else passed++;
        EF_enable     = 1'b0;
        S_AXIS_tvalid = 1'b0;
        @(negedge aclk);
        areset = 1'b0;
        step();
        q0 = '{7, -3};
        q1 = '{-9, 12};
        run_window(1, 0, 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        areset        = 1'b1;
        EF_enable     = 1'b0;
        EF_log_count  = '0;
        EF_shift      = '0;
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tdata  = '0;
        #1;
        test_reset();
        @(negedge aclk);
        areset = 1'b0;
        step();
        test_directed();
        test_random_valid();
        test_back_to_back();
        test_abort_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
